// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared constants and types for the VGA timing driver.
//             Default 640x480@60 Hz timing (25 MHz pixel clock), line and
//             frame totals derived from the porch/sync widths, RGB bit
//             positions within the 3-bit colour word, sync polarity, and the
//             bundle type carried through the sync/blank delay line.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

  // Vertical timing, in lines
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  // Clocks from coordinate change to the matching colour coming back
  localparam int c_color_latency = 1;

  // Bit positions inside the 3-bit colour word
  localparam int c_rgb_r = 2;
  localparam int c_rgb_g = 1;
  localparam int c_rgb_b = 0;

  // Level driven on hsync/vsync while the sync pulse is asserted
  localparam logic c_sync_asserted = 1'b0;

  // Stage-0 timing bundle that travels alongside the colour latency
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bundle_t;

  // Idle value: syncs deasserted, outside the visible area
  localparam sync_bundle_t c_sync_idle = '{
    hs:     ~c_sync_asserted,
    vs:     ~c_sync_asserted,
    active: 1'b0
  };

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : sync_delay
//  Purpose  : Fixed-depth shift register used to line up timing signals with
//             a downstream pipeline latency. Clears asynchronously to a
//             programmable idle value.
//  Ports    : clk   - clock
//             rst_n - asynchronous clear, active-low
//             din   - WIDTH-bit input sampled every clock
//             dout  - din delayed by DEPTH clocks
//  Revision : 1.0  initial release
// ============================================================================
module sync_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // All stages packed into one vector; the newest sample sits in the LSBs
  logic [DEPTH*WIDTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= RST_VAL;
        end else begin
          r_pipe <= din;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= {DEPTH{RST_VAL}};
        end else begin
          r_pipe <= {r_pipe[(DEPTH-1)*WIDTH-1:0], din};
        end
      end
    end
  endgenerate

  assign dout = r_pipe[DEPTH*WIDTH-1 -: WIDTH];

endmodule : sync_delay
`default_nettype wire

// File: rtl/vga_timing_driver.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_driver
//  Purpose  : VGA raster generator. Runs the horizontal/vertical counters,
//             hands half-resolution coordinates to the colour logic, and
//             re-aligns sync and blanking with the returned colour so all
//             five pins change together.
//  Ports    : clk          - pixel clock (25 MHz)
//             rst_n        - asynchronous reset, active-low
//             color        - {R,G,B} for the coordinate issued COLOR_LATENCY
//                            clocks earlier
//             xvga, yvga   - 320x240 coordinate, 0 outside the visible area
//             vblank_pulse - one clock at (h=0, v=V_ACTIVE), undelayed
//             vga_hs/vs    - sync pins, active-low
//             vga_r/g/b    - pixel pins, 0 during blanking
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE      = c_h_active,
  parameter int H_FP          = c_h_fp,
  parameter int H_SYNC        = c_h_sync,
  parameter int H_BP          = c_h_bp,
  parameter int V_ACTIVE      = c_v_active,
  parameter int V_FP          = c_v_fp,
  parameter int V_SYNC        = c_v_sync,
  parameter int V_BP          = c_v_bp,
  parameter int COLOR_LATENCY = c_color_latency
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] color,
  output logic [8:0] xvga,
  output logic [7:0] yvga,
  output logic       vblank_pulse,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);

  localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width versions of the timing boundaries
  localparam logic [9:0] c_h_last     = 10'(c_h_tot - 1);
  localparam logic [9:0] c_v_last     = 10'(c_v_tot - 1);
  localparam logic [9:0] c_h_act      = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act      = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]   r_h_cnt;
  logic [9:0]   r_v_cnt;
  logic         w_line_active;
  sync_bundle_t w_stage0;
  sync_bundle_t w_delayed;
  logic         r_hs;
  logic         r_vs;
  logic [2:0]   r_rgb;

  // --------------------------------------------------------------------------
  // Raster counters: line and frame wrap share the same edge at the last pixel
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage-0 decode straight from the counters
  // --------------------------------------------------------------------------
  assign w_line_active   = (r_v_cnt < c_v_act);
  assign w_stage0.active = (r_h_cnt < c_h_act) && w_line_active;
  assign w_stage0.hs     = ((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last))
                           ? c_sync_asserted : ~c_sync_asserted;
  assign w_stage0.vs     = ((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last))
                           ? c_sync_asserted : ~c_sync_asserted;

  // Clamping to 0 outside the visible area keeps the halved counters within
  // the 9/8-bit coordinate ports (v_cnt/2 would otherwise reach 262).
  assign xvga = w_stage0.active ? r_h_cnt[9:1] : '0;
  assign yvga = w_line_active   ? r_v_cnt[8:1] : '0;

  assign vblank_pulse = (r_h_cnt == '0) && (r_v_cnt == c_v_act);

  // --------------------------------------------------------------------------
  // Delay sync/blank by the colour round-trip so they meet the colour here
  // --------------------------------------------------------------------------
  sync_delay #(
    .DEPTH   (COLOR_LATENCY),
    .WIDTH   ($bits(sync_bundle_t)),
    .RST_VAL (c_sync_idle)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (w_stage0),
    .dout  (w_delayed)
  );

  // --------------------------------------------------------------------------
  // Pin register: colour is only ever looked at here, and only when visible
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs  <= ~c_sync_asserted;
      r_vs  <= ~c_sync_asserted;
      r_rgb <= 3'b000;
    end else begin
      r_hs  <= w_delayed.hs;
      r_vs  <= w_delayed.vs;
      r_rgb <= w_delayed.active ? color : 3'b000;
    end
  end

  assign vga_hs = r_hs;
  assign vga_vs = r_vs;
  assign vga_r  = r_rgb[c_rgb_r];
  assign vga_g  = r_rgb[c_rgb_g];
  assign vga_b  = r_rgb[c_rgb_b];

endmodule : vga_timing_driver
`default_nettype wire
